// File: rtl/memory_reader.sv
// memory_reader: burst read initiator for a synchronous-read memory.
// On start (sampled in idle) reads `length` consecutive words from `base_addr`,
// wrapping past WIDTH-1 to 0, and streams them out on a valid/ready interface
// with out_last on the final beat and a one-cycle done pulse afterwards.
// Ports:
//   clock, reset_n      clock, asynchronous active-low reset
//   start, base_addr,   burst request; base_addr/length sampled with start
//   length              (length 0..WIDTH)
//   busy, done          burst in progress / one-cycle completion pulse
//   raddr, mem_data     memory read address (registered) / read data,
//                       which is valid one clock after the memory samples raddr
//   out_data, out_valid, stream output with backpressure; out_last marks the
//   out_ready, out_last  final beat
module memory_reader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [$clog2(WIDTH)-1:0]   base_addr,
  input  logic [$clog2(WIDTH):0]     length,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH)-1:0]   raddr,
  input  logic [DEPTH-1:0]           mem_data,
  output logic [DEPTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int unsigned AW = $clog2(WIDTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t          state;
  logic [LW-1:0]   remaining;
  // Read pipeline: rd_p1 = raddr holds an issued read the memory samples next
  // edge; rd_p2 = mem_data carries that word and is captured next edge.
  logic            rd_p1, rd_p2;
  logic            last_p1, last_p2;
  // Buffer: the out_* registers are the head, s1/s2 are the entries behind it.
  // Two reads can be in flight, so three slots keep one beat per cycle.
  logic [DEPTH-1:0] s1_data, s2_data;
  logic             s1_valid, s2_valid, s1_last, s2_last;

  logic             pop_c, push_c, room_c, issue_c;
  logic [2:0]       occ_c;
  logic [AW-1:0]    next_addr_c;
  logic [DEPTH-1:0] n0_data, n1_data, n2_data;
  logic             n0_valid, n1_valid, n2_valid;
  logic             n0_last, n1_last, n2_last;

  // Issue control: buffered + in-flight words after this pop must leave a slot.
  always_comb begin
    pop_c       = out_valid & out_ready;
    push_c      = rd_p2;
    occ_c       = 3'(out_valid) + 3'(s1_valid) + 3'(s2_valid)
                + 3'(rd_p1) + 3'(rd_p2) - 3'(pop_c);
    room_c      = occ_c < 3'd3;
    issue_c     = (state == READ) && (remaining != '0) && room_c;
    next_addr_c = (raddr == LAST_ADDR) ? '0 : raddr + AW'(1);
  end

  // Buffer next state: shift on pop, then append the captured word at the
  // first free slot (valid slots are always contiguous from the head).
  always_comb begin
    n0_data = out_data; n0_valid = out_valid; n0_last = out_last;
    n1_data = s1_data;  n1_valid = s1_valid;  n1_last = s1_last;
    n2_data = s2_data;  n2_valid = s2_valid;  n2_last = s2_last;
    if (pop_c) begin
      n0_data = s1_data; n0_valid = s1_valid; n0_last = s1_last;
      n1_data = s2_data; n1_valid = s2_valid; n1_last = s2_last;
      n2_valid = 1'b0;
    end
    if (push_c) begin
      if (!n0_valid) begin
        n0_data = mem_data; n0_valid = 1'b1; n0_last = last_p2;
      end else if (!n1_valid) begin
        n1_data = mem_data; n1_valid = 1'b1; n1_last = last_p2;
      end else begin
        n2_data = mem_data; n2_valid = 1'b1; n2_last = last_p2;
      end
    end
  end

  // Burst FSM, read issue and buffer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      raddr     <= '0;
      remaining <= '0;
      rd_p1     <= 1'b0;
      rd_p2     <= 1'b0;
      last_p1   <= 1'b0;
      last_p2   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_data   <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
    end else begin
      out_data  <= n0_data;
      out_valid <= n0_valid;
      out_last  <= n0_last;
      s1_data   <= n1_data;
      s1_valid  <= n1_valid;
      s1_last   <= n1_last;
      s2_data   <= n2_data;
      s2_valid  <= n2_valid;
      s2_last   <= n2_last;
      rd_p2     <= rd_p1;
      last_p2   <= last_p1;
      rd_p1     <= 1'b0;
      last_p1   <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              // First read goes out on the start edge itself.
              busy      <= 1'b1;
              raddr     <= base_addr;
              rd_p1     <= 1'b1;
              last_p1   <= (length == LW'(1));
              remaining <= length - LW'(1);
              state     <= READ;
            end
          end
        end
        READ: begin
          if (issue_c) begin
            raddr     <= next_addr_c;
            remaining <= remaining - LW'(1);
            rd_p1     <= 1'b1;
            last_p1   <= (remaining == LW'(1));
          end
          if (pop_c && out_last) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (remaining == '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Popping the last-flagged beat means nothing is buffered or in flight.
          if (pop_c && out_last) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
